// File: rtl/riscv_core_mem_arbiter.sv
// Round-robin arbiter sharing one val/rdy memory port between the instruction and data
// request streams; an in-order tag FIFO steers each response back to its issuer.
module riscv_core_mem_arbiter #(
  parameter int REQ_SZ  = 67,
  parameter int RESP_SZ = 35,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQ_SZ-1:0]          imemreq_msg,
  input  logic                       imemreq_val,
  output logic                       imemreq_rdy,
  output logic [RESP_SZ-1:0]         imemresp_msg,
  output logic                       imemresp_val,
  input  logic [REQ_SZ-1:0]          dmemreq_msg,
  input  logic                       dmemreq_val,
  output logic                       dmemreq_rdy,
  output logic [RESP_SZ-1:0]         dmemresp_msg,
  output logic                       dmemresp_val,
  output logic [REQ_SZ-1:0]          memreq_msg,
  output logic                       memreq_val,
  input  logic                       memreq_rdy,
  input  logic [RESP_SZ-1:0]         memresp_msg,
  input  logic                       memresp_val,
  output logic                       err_resp,
  output logic [$clog2(MAX_OUT):0]   outstanding
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  logic [MAX_OUT-1:0] fifo_q;
  logic [PW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, err_q;
  logic               full, empty, gnt, push, pop, head;

  assign full  = (cnt_q == CW'(MAX_OUT));
  assign empty = (cnt_q == '0);

  // gnt: 0 = IMEM, 1 = DMEM. On conflict the requester that did not win last transfer wins.
  assign gnt  = dmemreq_val & (~imemreq_val | ~last_q);
  assign head = fifo_q[rd_q];

  assign memreq_val  = (imemreq_val | dmemreq_val) & ~full & ~reset;
  assign memreq_msg  = (gnt & memreq_val) ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = ~gnt & memreq_rdy & memreq_val;
  assign dmemreq_rdy =  gnt & memreq_rdy & memreq_val;
  assign push        = memreq_val & memreq_rdy;

  // A response with nothing outstanding is dropped and only flags the error.
  assign pop          = memresp_val & ~empty & ~reset;
  assign imemresp_val = pop & ~head;
  assign dmemresp_val = pop &  head;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;

  assign err_resp    = err_q;
  assign outstanding = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= gnt;
        wr_q         <= wr_q + PW'(1);
        last_q       <= gnt;
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
      if (memresp_val && empty) err_q <= 1'b1;
    end
  end
endmodule
